// File: rtl/vga_scanout.sv
`default_nettype none
// ----------------------------------------------------------------------------
// vga_scanout : VGA timing counters, pixel fetch addressing and aligned output
// Rev 1.0
// ----------------------------------------------------------------------------
module vga_scanout #(
  parameter int H_ACTIVE      = 640,
  parameter int H_FP          = 16,
  parameter int H_SYNC        = 96,
  parameter int H_BP          = 48,
  parameter int V_ACTIVE      = 480,
  parameter int V_FP          = 10,
  parameter int V_SYNC        = 2,
  parameter int V_BP          = 33,
  parameter bit HSYNC_POL     = 1'b0,
  parameter bit VSYNC_POL     = 1'b0,
  parameter int FETCH_LATENCY = 2,
  parameter int COLOR_W       = 8,
  parameter int CNT_W         = 11
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               pixel_en,
  input  logic [COLOR_W-1:0] red_in,
  input  logic [COLOR_W-1:0] green_in,
  input  logic [COLOR_W-1:0] blue_in,
  output logic [CNT_W-1:0]   x_address,
  output logic [CNT_W-1:0]   y_address,
  output logic               fetch_valid,
  output logic               line_start,
  output logic               frame_start,
  output logic               h_sync,
  output logic               v_sync,
  output logic               de,
  output logic [COLOR_W-1:0] red,
  output logic [COLOR_W-1:0] green,
  output logic [COLOR_W-1:0] blue,
  output logic [15:0]        frame_count
);

  localparam int c_h_total = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int c_v_total = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CNT_W-1:0] c_h_active     = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] c_h_sync_start = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] c_h_sync_end   = CNT_W'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [CNT_W-1:0] c_h_last       = CNT_W'(c_h_total - 1);
  localparam logic [CNT_W-1:0] c_v_active     = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] c_v_sync_start = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] c_v_sync_end   = CNT_W'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic [CNT_W-1:0] c_v_last       = CNT_W'(c_v_total - 1);

  logic [CNT_W-1:0]     r_h_cnt;
  logic [CNT_W-1:0]     r_v_cnt;
  logic                 w_h_last;
  logic                 w_v_last;
  logic                 w_fetch_valid;
  logic                 w_hs_raw;
  logic                 w_vs_raw;
  logic                 w_fv_lat;
  logic [FETCH_LATENCY:0] r_hs_dly;
  logic [FETCH_LATENCY:0] r_vs_dly;
  logic [FETCH_LATENCY:0] r_de_dly;
  logic [COLOR_W-1:0]   r_red;
  logic [COLOR_W-1:0]   r_green;
  logic [COLOR_W-1:0]   r_blue;
  logic [15:0]          r_frame_count;

  assign w_h_last = (r_h_cnt == c_h_last);
  assign w_v_last = (r_v_cnt == c_v_last);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_h_cnt <= '0;
      r_v_cnt <= '0;
    end else if (pixel_en) begin
      if (w_h_last) begin
        r_h_cnt <= '0;
        r_v_cnt <= w_v_last ? '0 : r_v_cnt + CNT_W'(1);
      end else begin
        r_h_cnt <= r_h_cnt + CNT_W'(1);
      end
    end
  end

  // Fetch stage: purely combinational from the counters.
  assign w_fetch_valid = (r_h_cnt < c_h_active) && (r_v_cnt < c_v_active);
  assign fetch_valid   = w_fetch_valid;
  assign x_address     = w_fetch_valid ? r_h_cnt : '0;
  assign y_address     = w_fetch_valid ? r_v_cnt : '0;
  assign line_start    = pixel_en && (r_h_cnt == '0);
  assign frame_start   = pixel_en && (r_h_cnt == '0) && (r_v_cnt == '0);

  assign w_hs_raw = (r_h_cnt >= c_h_sync_start) && (r_h_cnt <= c_h_sync_end);
  assign w_vs_raw = (r_v_cnt >= c_v_sync_start) && (r_v_cnt <= c_v_sync_end);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_hs_dly <= '0;
      r_vs_dly <= '0;
      r_de_dly <= '0;
    end else if (pixel_en) begin
      r_hs_dly[0] <= w_hs_raw;
      r_vs_dly[0] <= w_vs_raw;
      r_de_dly[0] <= w_fetch_valid;
      for (int i = 1; i <= FETCH_LATENCY; i++) begin
        r_hs_dly[i] <= r_hs_dly[i-1];
        r_vs_dly[i] <= r_vs_dly[i-1];
        r_de_dly[i] <= r_de_dly[i-1];
      end
    end
  end

  // Validity of the pixel whose data is on the inputs right now.
  generate
    if (FETCH_LATENCY == 0) begin : g_lat_zero
      assign w_fv_lat = w_fetch_valid;
    end else begin : g_lat_pipe
      assign w_fv_lat = r_de_dly[FETCH_LATENCY-1];
    end
  endgenerate

  always_ff @(posedge clock) begin
    if (reset) begin
      r_red   <= '0;
      r_green <= '0;
      r_blue  <= '0;
    end else if (pixel_en) begin
      r_red   <= w_fv_lat ? red_in   : '0;
      r_green <= w_fv_lat ? green_in : '0;
      r_blue  <= w_fv_lat ? blue_in  : '0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_frame_count <= '0;
    end else if (pixel_en && w_h_last && w_v_last) begin
      r_frame_count <= r_frame_count + 16'd1;
    end
  end

  assign h_sync      = r_hs_dly[FETCH_LATENCY] ^ ~HSYNC_POL;
  assign v_sync      = r_vs_dly[FETCH_LATENCY] ^ ~VSYNC_POL;
  assign de          = r_de_dly[FETCH_LATENCY];
  assign red         = r_red;
  assign green       = r_green;
  assign blue        = r_blue;
  assign frame_count = r_frame_count;

endmodule
`default_nettype wire

// File: doc/vga_scanout.md
VGA_SCANOUT -- requirements
Module: vga_scanout

Interface
REQ-001 Parameter H_ACTIVE, default 640, sets the visible pixels per line.
REQ-002 Parameters H_FP, H_SYNC and H_BP, defaults 16/96/48, set the horizontal front porch, sync and back porch in pixels.
REQ-003 Parameter V_ACTIVE, default 480, sets the visible lines per frame.
REQ-004 Parameters V_FP, V_SYNC and V_BP, defaults 10/2/33, set the vertical front porch, sync and back porch in lines.
REQ-005 Parameters HSYNC_POL and VSYNC_POL, default 0, set the asserted sync level (0 = active-low).
REQ-006 Parameter FETCH_LATENCY, default 2, legal 0..7, is the pixel-source read latency in pixel steps.
REQ-007 Parameter COLOR_W, default 8, is the bits per colour channel.
REQ-008 Parameter CNT_W, default 11, is the counter/address width and SHALL hold H_TOTAL-1 and V_TOTAL-1.
REQ-009 Port clock, input, 1 bit: the single clock.
REQ-010 Port reset, input, 1 bit: synchronous, active-high reset.
REQ-011 Port pixel_en, input, 1 bit: pixel-step enable; all state advances only when it is 1.
REQ-012 Ports red_in, green_in and blue_in, input, COLOR_W each: pixel data from the source.
REQ-013 Ports x_address and y_address, output, CNT_W each: fetch coordinates, 0 when outside the active area.
REQ-014 Port fetch_valid, output, 1 bit: x_address and y_address address a visible pixel.
REQ-015 Ports line_start and frame_start, output, 1 bit each: single-clock pulses at the fetch stage.
REQ-016 Ports h_sync, v_sync and de, output, 1 bit each: aligned syncs and data-enable (de drives DAC BLANK_N).
REQ-017 Ports red, green and blue, output, COLOR_W each: aligned colour.
REQ-018 Port frame_count, output, 16 bits: count of completed frames.

Function
REQ-019 The design SHALL use H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP and V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP.
REQ-020 h_cnt SHALL count 0..H_TOTAL-1 and wrap to 0, advancing only on clocks with pixel_en=1.
REQ-021 v_cnt SHALL increment on each h_cnt wrap and wrap from V_TOTAL-1 to 0.
REQ-022 Line order SHALL be active, front porch, sync, back porch; frame order is the same in lines.
REQ-023 The fetch stage SHALL be combinational from the counters: fetch_valid = (h_cnt<H_ACTIVE)&(v_cnt<V_ACTIVE); x_address = fetch_valid ? h_cnt : 0; y_address = fetch_valid ? v_cnt : 0.
REQ-024 line_start SHALL be 1 when h_cnt==0 and pixel_en=1.
REQ-025 frame_start SHALL be 1 when h_cnt==0, v_cnt==0 and pixel_en=1.
REQ-026 Raw hsync SHALL be asserted for h_cnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1].
REQ-027 Raw vsync SHALL be asserted for v_cnt in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1], spanning whole lines.
REQ-028 Raw hsync, raw vsync and fetch_valid SHALL pass through a delay line of FETCH_LATENCY+1 pixel-steps, clocked only when pixel_en=1, and drive h_sync (XOR ~HSYNC_POL), v_sync (XOR ~VSYNC_POL) and de.
REQ-029 The colour register SHALL load red_in/green_in/blue_in when pixel_en=1, loading the inputs if the fetch_valid delayed by FETCH_LATENCY is 1 and 0 otherwise.
REQ-030 Total latency from counter state to outputs SHALL be FETCH_LATENCY+1 pixel-steps; data returned FETCH_LATENCY steps after its address SHALL appear with the matching de.
REQ-031 red, green and blue SHALL be 0 whenever de=0.
REQ-032 frame_count SHALL increment, wrapping 0xFFFF to 0, on the step where h_cnt==H_TOTAL-1 and v_cnt==V_TOTAL-1.
REQ-033 With pixel_en=0 every register SHALL hold its value; only the combinational pulses drop to 0.

Reset
REQ-034 Reset SHALL win over pixel_en: h_cnt=v_cnt=0, all delay stages cleared (syncs deasserted, de=0), colour=0, frame_count=0.
REQ-035 For the first FETCH_LATENCY+1 pixel-steps after reset, the outputs SHALL be h_sync/v_sync inactive, de=0 and colour 0.
REQ-036 Reset asserted mid-frame SHALL produce frame_start on the first pixel_en=1 clock after reset release.

Verification
Bench parameters: H 4/1/2/1 (H_TOTAL 8), V 3/1/1/1 (V_TOTAL 6), FETCH_LATENCY 2, pol 0.
REQ-037 Reset, then pixel_en=1 constantly -> frame_start at clock 0 and every 48 clocks; line_start every 8 clocks; frame_count=1 after 48 steps.
REQ-038 Source echoes red_in = {x,y} with 2-step latency -> de high for steps 3..6 of line 0, and red sequence 00,10,20,30 at those steps.
REQ-039 Steady run -> h_sync low for exactly 2 clocks per line, at output steps 8..9 mod 8 of the delayed stream; v_sync low for exactly 8 clocks per frame.
REQ-040 pixel_en toggling 1,0,1,0 -> outputs are identical to the REQ-037 run with every value stretched to 2 clocks, and pulses appear only on enabled clocks.
REQ-041 Reset asserted at v_cnt=2, h_cnt=5 -> next clock de=0, colour 0, frame_count=0; frame_start on the first enabled clock after release.
REQ-042 frame_count preloaded near wrap (force, 0xFFFF) plus one frame -> frame_count=0x0000.
